// File: rtl/zipdma_txgears.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : zipdma_txgears
// Brief   : Realigns a packed byte stream onto destination lanes starting at
//           a per-packet offset. Define ZIPDMA_TXGEARS_ZEROFILL_EN to force
//           unused output lanes to 8'h00.
// Revision: 1.0 - initial release
// ============================================================================
module zipdma_txgears #(
    parameter int BUS_WIDTH         = 64,
    parameter bit OPT_LITTLE_ENDIAN = 1'b0,
    localparam int WBLSB            = $clog2(BUS_WIDTH / 8)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_soft_reset,
    input  logic [WBLSB-1:0]     i_offset,
    input  logic                 S_VALID,
    output logic                 S_READY,
    input  logic [BUS_WIDTH-1:0] S_DATA,
    input  logic [WBLSB:0]       S_BYTES,
    input  logic                 S_LAST,
    output logic                 M_VALID,
    input  logic                 M_READY,
    output logic [BUS_WIDTH-1:0] M_DATA,
    output logic [WBLSB:0]       M_BYTES,
    output logic                 M_LAST
);

    localparam int c_DW = BUS_WIDTH;
    localparam int c_NB = BUS_WIDTH / 8;
    localparam int c_FW = WBLSB + 2;
    localparam int c_CW = WBLSB + 3;
    localparam logic [c_FW-1:0] c_NB_F = c_FW'(c_NB);
    localparam logic [c_CW-1:0] c_NB_C = c_CW'(c_NB);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t              r_state;
    logic [2*c_DW-1:0]   r_sreg;
    logic [c_FW-1:0]     r_fill;
    logic                r_m_valid;
    logic                r_m_last;
    logic [c_DW-1:0]     r_m_data;
    logic [WBLSB:0]      r_m_bytes;

    logic [c_DW-1:0]     w_s_lanes;
    logic [c_DW-1:0]     w_s_masked;
    logic [c_DW-1:0]     w_out_lanes;
    logic                w_accept;
    logic                w_take;
    logic                w_out_free;
    logic                w_first;
    logic                w_have_last;
    logic                w_emit;
    logic                w_last_out;
    logic [c_CW-1:0]     w_pad;
    logic [c_CW-1:0]     w_base;
    logic [c_CW-1:0]     w_cnt;
    logic [c_CW-1:0]     w_n;
    logic [3*c_DW-1:0]   w_temp;

    assign S_READY    = i_reset_n && (r_state != ST_FLUSH) && !r_m_last &&
                        (!r_m_valid || M_READY || (r_fill < c_NB_F));
    assign w_accept   = S_VALID && S_READY;
    assign w_take     = r_m_valid && M_READY;
    assign w_out_free = !r_m_valid || M_READY;
    assign w_first    = (r_state == ST_IDLE) && w_accept;

    // The start offset acts as leading padding in the buffer for the first beat only
    assign w_pad      = w_first ? {{(c_CW-WBLSB){1'b0}}, i_offset} : '0;
    assign w_base     = w_first ? w_pad : {{(c_CW-c_FW){1'b0}}, r_fill};
    assign w_cnt      = w_base + (w_accept ? {{(c_CW-WBLSB-1){1'b0}}, S_BYTES} : '0);
    assign w_have_last = (r_state == ST_FLUSH) || (w_accept && S_LAST);
    assign w_emit     = w_out_free && !r_m_last && (w_cnt != '0) &&
                        ((w_cnt >= c_NB_C) || w_have_last);
    assign w_n        = (w_cnt >= c_NB_C) ? c_NB_C : w_cnt;
    assign w_last_out = w_have_last && (w_cnt <= c_NB_C);

    // Buffer bytes beyond the fill level are always zero, so OR-merging is safe
    assign w_temp = {{c_DW{1'b0}}, r_sreg} |
                    ({{(2*c_DW){1'b0}}, w_s_masked} << {w_base, 3'b000});

    for (genvar gi = 0; gi < c_NB; gi++) begin : g_lane
        if (OPT_LITTLE_ENDIAN) begin : g_le
            assign w_s_lanes[8*gi +: 8] = S_DATA[8*gi +: 8];
            assign M_DATA[8*gi +: 8]    = r_m_data[8*gi +: 8];
        end else begin : g_be
            assign w_s_lanes[8*gi +: 8]       = S_DATA[c_DW-8-8*gi +: 8];
            assign M_DATA[c_DW-8-8*gi +: 8]   = r_m_data[8*gi +: 8];
        end

        assign w_s_masked[8*gi +: 8] = (w_accept && ((WBLSB+1)'(gi) < S_BYTES)) ?
                                       w_s_lanes[8*gi +: 8] : 8'h00;
`ifdef ZIPDMA_TXGEARS_ZEROFILL_EN
        assign w_out_lanes[8*gi +: 8] = ((c_CW'(gi) >= w_pad) && (c_CW'(gi) < w_n)) ?
                                        w_temp[8*gi +: 8] : 8'h00;
`else
        assign w_out_lanes[8*gi +: 8] = w_temp[8*gi +: 8];
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_sreg    <= '0;
            r_fill    <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_m_bytes <= '0;
        end else if (i_soft_reset || (w_take && r_m_last)) begin
            r_state   <= ST_IDLE;
            r_sreg    <= '0;
            r_fill    <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_m_bytes <= '0;
        end else if (w_emit) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_out_lanes;
            r_m_bytes <= (WBLSB+1)'(w_n - w_pad);
            r_m_last  <= w_last_out;
            r_sreg    <= w_last_out ? '0 : w_temp[3*c_DW-1:c_DW];
            r_fill    <= w_last_out ? '0 : c_FW'(w_cnt - w_n);
            // A pending last beat keeps the packet open until it is taken
            if (w_last_out)
                r_state <= ST_ACTIVE;
            else if (w_have_last)
                r_state <= ST_FLUSH;
            else
                r_state <= ST_ACTIVE;
        end else begin
            if (w_take)
                r_m_valid <= 1'b0;
            if (w_accept) begin
                r_sreg  <= w_temp[2*c_DW-1:0];
                r_fill  <= c_FW'(w_cnt);
                r_state <= S_LAST ? ST_FLUSH : ST_ACTIVE;
            end
        end
    end

    assign M_VALID = r_m_valid;
    assign M_BYTES = r_m_bytes;
    assign M_LAST  = r_m_last;

endmodule
`default_nettype wire

// File: tb/tb_zipdma_txgears.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for zipdma_txgears: directed corner cases plus randomized packets,
// checked by a scoreboard fed from a byte-level lane-placement model.
module tb_zipdma_txgears;

    localparam int DW = 64;
    localparam int NB = 8;
    localparam int WB = 3;

    logic          clk = 1'b0;
    logic          i_reset_n;
    logic          i_soft_reset;
    logic [WB-1:0] i_offset;
    logic          S_VALID;
    logic          S_READY;
    logic [DW-1:0] S_DATA;
    logic [WB:0]   S_BYTES;
    logic          S_LAST;
    logic          M_VALID;
    logic          M_READY;
    logic [DW-1:0] M_DATA;
    logic [WB:0]   M_BYTES;
    logic          M_LAST;

    typedef logic [7:0] bytes_t [$];
    typedef struct {
        logic [DW-1:0] data;
        logic [NB-1:0] mask;
        int            nb;
        bit            last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    rdy_auto = 1'b0;
    bit    rdy_fixed = 1'b0;
    int    rdy_pct = 100;

    zipdma_txgears #(
        .BUS_WIDTH        (DW),
        .OPT_LITTLE_ENDIAN(1'b0)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (i_reset_n),
        .i_soft_reset(i_soft_reset),
        .i_offset    (i_offset),
        .S_VALID     (S_VALID),
        .S_READY     (S_READY),
        .S_DATA      (S_DATA),
        .S_BYTES     (S_BYTES),
        .S_LAST      (S_LAST),
        .M_VALID     (M_VALID),
        .M_READY     (M_READY),
        .M_DATA      (M_DATA),
        .M_BYTES     (M_BYTES),
        .M_LAST      (M_LAST)
    );

    always #5 clk = ~clk;

    // Lane 0 is the most significant byte on the bus; reversal is self-inverse.
    function automatic logic [DW-1:0] swap_lanes(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = v[DW-8-8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: slice the packet into beats by lane arithmetic.
    function automatic void model_push(input int off, input bytes_t pkt);
        int lane = off;
        int idx  = 0;
        int rem  = pkt.size();
        while (rem > 0) begin
            beat_t b;
            int n;
            n = (NB - lane < rem) ? NB - lane : rem;
            b.data = '0;
            b.mask = '0;
            for (int k = 0; k < n; k++) begin
                b.data[8*(lane+k) +: 8] = pkt[idx+k];
                b.mask[lane+k] = 1'b1;
            end
            b.nb   = n;
            b.last = (rem == n);
            exp_q.push_back(b);
            idx  += n;
            rem  -= n;
            lane = 0;
        end
    endfunction

    function automatic bytes_t make_pkt(input int len, input bit inc);
        bytes_t p;
        for (int i = 0; i < len; i++) p.push_back(inc ? 8'(i) : 8'($urandom));
        return p;
    endfunction

    // Monitor: compares every taken beat with the scoreboard head.
    always @(negedge clk) begin : mon
        beat_t         e;
        logic [DW-1:0] got;
        bit            bad;
        if (i_reset_n && M_VALID && M_LAST) begin
            n_cmp++;
            if (S_READY !== 1'b0) begin
                n_err++;
                $display("FAIL sready_during_last: got %b, expected 0", S_READY);
            end
        end
        if (i_reset_n && M_VALID && M_READY) begin
            got = swap_lanes(M_DATA);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat_unexpected: got bytes=%0d last=%0b lanes=%h, expected no beat",
                         M_BYTES, M_LAST, got);
            end else begin
                e   = exp_q.pop_front();
                bad = (M_BYTES !== 4'(e.nb)) || (M_LAST !== e.last);
                for (int i = 0; i < NB; i++) begin
                    if (e.mask[i] && (got[8*i +: 8] !== e.data[8*i +: 8])) bad = 1'b1;
`ifdef ZIPDMA_TXGEARS_ZEROFILL_EN
                    if (!e.mask[i] && (got[8*i +: 8] !== 8'h00)) bad = 1'b1;
`endif
                end
                if (bad) begin
                    n_err++;
                    $display("FAIL beat_data: got bytes=%0d last=%0b lanes=%h, expected bytes=%0d last=%0b lanes=%h mask=%b",
                             M_BYTES, M_LAST, got, e.nb, e.last, e.data, e.mask);
                end
            end
        end
    end

    initial begin
        M_READY = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            M_READY = rdy_auto ? ($urandom_range(0, 99) < rdy_pct) : rdy_fixed;
        end
    end

    task automatic drive_beat(input logic [WB-1:0] off, input logic [DW-1:0] lanes,
                              input int n, input bit last, output bit ok);
        bit acc;
        i_offset = off;
        S_DATA   = swap_lanes(lanes);
        S_BYTES  = 4'(n);
        S_LAST   = last;
        S_VALID  = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc = S_READY;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        S_VALID = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no accept in 300 cycles, expected accept");
        end
    endtask

    task automatic send_packet(input logic [WB-1:0] off, input bytes_t pkt, input int gap_max);
        int idx = 0;
        model_push(int'(off), pkt);
        while (idx < pkt.size()) begin
            int            n;
            logic [DW-1:0] lanes;
            bit            ok;
            n = (pkt.size() - idx < NB) ? pkt.size() - idx : NB;
            lanes = {$urandom, $urandom};
            for (int k = 0; k < n; k++) lanes[8*k +: 8] = pkt[idx+k];
            drive_beat((idx == 0) ? off : WB'($urandom), lanes, n, (idx + n == pkt.size()), ok);
            if (!ok) break;
            idx += n;
            for (int g = 0; g < $urandom_range(0, gap_max); g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 600 && exp_q.size() != 0; c++) @(posedge clk);
        @(posedge clk);
        #1;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bytes_t        pkt;
        bit            ok;
        logic [DW-1:0] lanes;
        i_reset_n    = 1'b0;
        i_soft_reset = 1'b0;
        i_offset     = '0;
        S_VALID      = 1'b0;
        S_DATA       = '0;
        S_BYTES      = '0;
        S_LAST       = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(M_VALID), 64'd0);
        chk("rst_m_last",  64'(M_LAST),  64'd0);
        chk("rst_m_bytes", 64'(M_BYTES), 64'd0);
        chk("rst_s_ready", 64'(S_READY), 64'd0);
        i_reset_n = 1'b1;
        rdy_fixed = 1'b1;
        @(posedge clk);
        #1;

        // Offset 3, bytes 00..0F in two beats
        send_packet(3'd3, make_pkt(16, 1'b1), 0);
        wait_drain("drain_off3");

        // Offset 0, single full last beat: latency and one-beat output
        chk("idle_m_valid", 64'(M_VALID), 64'd0);
        pkt = make_pkt(8, 1'b0);
        model_push(0, pkt);
        lanes = '0;
        for (int k = 0; k < 8; k++) lanes[8*k +: 8] = pkt[k];
        drive_beat(3'd0, lanes, 8, 1'b1, ok);
        @(negedge clk);
        chk("lat1_m_valid", 64'(M_VALID), 64'd1);
        chk("lat1_m_last",  64'(M_LAST),  64'd1);
        chk("lat1_m_bytes", 64'(M_BYTES), 64'd8);
        @(negedge clk);
        chk("lat1_after_valid", 64'(M_VALID), 64'd0);
        @(posedge clk);
        #1;

        // Offset 7, 5-byte last beat: split with flush
        pkt = make_pkt(5, 1'b0);
        model_push(7, pkt);
        lanes = '0;
        for (int k = 0; k < 5; k++) lanes[8*k +: 8] = pkt[k];
        drive_beat(3'd7, lanes, 5, 1'b1, ok);
        @(negedge clk);
        chk("off7_b1_bytes", 64'(M_BYTES), 64'd1);
        chk("off7_b1_last",  64'(M_LAST),  64'd0);
        chk("off7_b1_sready", 64'(S_READY), 64'd0);
        @(negedge clk);
        chk("off7_b2_bytes", 64'(M_BYTES), 64'd4);
        chk("off7_b2_last",  64'(M_LAST),  64'd1);
        @(negedge clk);
        chk("off7_end_valid",  64'(M_VALID), 64'd0);
        chk("off7_end_sready", 64'(S_READY), 64'd1);
        @(posedge clk);
        #1;

        // Offset 6, 2-byte last beat held under backpressure
        rdy_fixed = 1'b0;
        pkt = make_pkt(2, 1'b0);
        model_push(6, pkt);
        lanes = '0;
        lanes[7:0]  = pkt[0];
        lanes[15:8] = pkt[1];
        drive_beat(3'd6, lanes, 2, 1'b1, ok);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_valid", 64'(M_VALID), 64'd1);
            chk("hold_bytes", 64'(M_BYTES), 64'd2);
            chk("hold_last",  64'(M_LAST),  64'd1);
            chk("hold_lanes67", 64'(swap_lanes(M_DATA) >> 48), {48'd0, pkt[1], pkt[0]});
            @(posedge clk);
            #1;
        end
        rdy_fixed = 1'b1;
        wait_drain("drain_hold");

        // Asynchronous reset mid-packet, then a new packet at offset 2
        rdy_fixed = 1'b0;
        @(posedge clk);
        #1;
        drive_beat(3'd5, {$urandom, $urandom}, 8, 1'b0, ok);
        @(negedge clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_m_valid", 64'(M_VALID), 64'd0);
        chk("arst_m_bytes", 64'(M_BYTES), 64'd0);
        chk("arst_s_ready", 64'(S_READY), 64'd0);
        @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        rdy_fixed = 1'b1;
        send_packet(3'd2, make_pkt(13, 1'b0), 1);
        wait_drain("drain_arst");

        // Soft reset mid-packet
        rdy_fixed = 1'b0;
        @(posedge clk);
        #1;
        drive_beat(3'd1, {$urandom, $urandom}, 8, 1'b0, ok);
        i_soft_reset = 1'b1;
        @(posedge clk);
        #1;
        i_soft_reset = 1'b0;
        chk("srst_m_valid", 64'(M_VALID), 64'd0);
        chk("srst_s_ready", 64'(S_READY), 64'd1);
        rdy_fixed = 1'b1;
        send_packet(3'd4, make_pkt(20, 1'b0), 1);
        wait_drain("drain_srst");

        // Randomized packets with random backpressure
        rdy_auto = 1'b1;
        for (int p = 0; p < 40; p++) begin
            rdy_pct = $urandom_range(30, 100);
            send_packet(WB'($urandom), make_pkt($urandom_range(1, 40), 1'b0), 2);
        end
        rdy_auto  = 1'b0;
        rdy_fixed = 1'b1;
        wait_drain("drain_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
